// File: rtl/prom_boot_pkg.sv
// prom_boot_pkg: shared widths, FSM encoding and PROM address helper for the boot loader.
`default_nettype none

package prom_boot_pkg;

    localparam int PROM_AW        = 9;
    localparam int PROM_DW        = 8;
    localparam int UWORD_W        = 48;
    localparam int BYTES_PER_WORD = 6;
    localparam int CM_AW          = 14;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // 6*word + lane, computed with shifts so every term stays PROM_AW bits wide
    function automatic logic [PROM_AW-1:0] byte_addr(input logic [PROM_AW-1:0] word,
                                                     input logic [2:0]         lane);
        return (word << 2) + (word << 1) + {6'b000000, lane};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prom_byte_fetch.sv
// prom_byte_fetch: drives PROM address/CE for one byte access and times the ACCESS_CYCLES wait.
`default_nettype none

module prom_byte_fetch
    import prom_boot_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    input  logic [PROM_AW-1:0] req_addr,
    input  logic [PROM_DW-1:0] prom_d,
    output logic [PROM_AW-1:0] prom_a,
    output logic               prom_ce_n,
    output logic               wait_done,
    output logic               byte_valid,
    output logic [PROM_DW-1:0] byte_data
);

    localparam logic [3:0] C_PRE  = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] C_LAST = 4'(ACCESS_CYCLES);

    logic       active;
    logic [3:0] cnt;

    // cnt 0..ACCESS_CYCLES-1 is the wait, cnt == ACCESS_CYCLES is the sample clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prom_a    <= '0;
            prom_ce_n <= 1'b1;
            active    <= 1'b0;
            cnt       <= '0;
        end else if (req) begin
            prom_a    <= req_addr;
            prom_ce_n <= 1'b0;
            active    <= 1'b1;
            cnt       <= '0;
        end else if (active) begin
            if (cnt == C_LAST) begin
                prom_ce_n <= 1'b1;
                active    <= 1'b0;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign wait_done  = active && (cnt == C_PRE);
    assign byte_valid = active && (cnt == C_LAST);
    assign byte_data  = prom_d;

endmodule

`default_nettype wire

// File: rtl/prom_boot_reader.sv
// prom_boot_reader: loads NUM_WORDS 48-bit words from a byte-wide PROM into control memory.
// Optional PROM_CHECKSUM_EN adds an 8-bit checksum over all bytes plus PROM byte 511.
`default_nettype none

module prom_boot_reader
    import prom_boot_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int NUM_WORDS     = 85
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [PROM_AW-1:0] prom_a,
    output logic               prom_ce_n,
    input  logic [PROM_DW-1:0] prom_d,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [CM_AW-1:0]   wr_addr,
    output logic [UWORD_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               csum_ok
);

    localparam logic [CM_AW-1:0] LAST_WORD = CM_AW'(NUM_WORDS - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(BYTES_PER_WORD - 1);
`ifdef PROM_CHECKSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic [2:0]         state;
    logic [2:0]         byte_cnt;
    logic [CM_AW-1:0]   word_cnt;
    logic               fetch_req;
    logic [PROM_AW-1:0] fetch_addr;
    logic               wait_done;
    logic               byte_valid;
    logic [PROM_DW-1:0] byte_data;
    logic               csum_rd;
    logic               csum_pass;

    assign wr_valid = (state == S_EMIT);
    assign wr_addr  = word_cnt;

    // Launch a byte access on every transition into FETCH
    always_comb begin
        fetch_req  = 1'b0;
        fetch_addr = '0;
        case (state)
            S_IDLE: begin
                fetch_req = start;
            end
            S_CAPTURE: begin
                if (byte_valid && !csum_rd && byte_cnt != LAST_BYTE) begin
                    fetch_req  = 1'b1;
                    fetch_addr = byte_addr(word_cnt[PROM_AW-1:0], byte_cnt + 3'd1);
                end
            end
            S_EMIT: begin
                if (wr_ready) begin
                    if (word_cnt != LAST_WORD) begin
                        fetch_req  = 1'b1;
                        fetch_addr = byte_addr(word_cnt[PROM_AW-1:0] + 9'd1, 3'd0);
                    end else if (HAS_CSUM) begin
                        fetch_req  = 1'b1;
                        fetch_addr = '1;
                    end
                end
            end
            default: ;
        endcase
    end

    prom_byte_fetch #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_fetch (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (fetch_req),
        .req_addr  (fetch_addr),
        .prom_d    (prom_d),
        .prom_a    (prom_a),
        .prom_ce_n (prom_ce_n),
        .wait_done (wait_done),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

`ifdef PROM_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum     <= '0;
            csum_rd <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sum     <= '0;
            csum_rd <= 1'b0;
        end else begin
            if (state == S_CAPTURE && byte_valid)
                sum <= sum + byte_data;
            if (state == S_EMIT && wr_ready && word_cnt == LAST_WORD)
                csum_rd <= 1'b1;
        end
    end

    assign csum_pass = ((sum + byte_data) == 8'd0);
`else
    assign csum_rd   = 1'b0;
    assign csum_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            csum_ok  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        csum_ok  <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (wait_done)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (byte_valid) begin
                        if (csum_rd) begin
                            csum_ok <= csum_pass;
                            done    <= 1'b1;
                            state   <= S_FINISH;
                        end else begin
                            wr_data[{byte_cnt, 3'b000} +: PROM_DW] <= byte_data;
                            if (byte_cnt != LAST_BYTE) begin
                                byte_cnt <= byte_cnt + 3'd1;
                                state    <= S_FETCH;
                            end else begin
                                state <= S_EMIT;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (wr_ready) begin
                        if (word_cnt != LAST_WORD) begin
                            word_cnt <= word_cnt + 14'd1;
                            byte_cnt <= '0;
                            state    <= S_FETCH;
                        end else if (HAS_CSUM) begin
                            state <= S_FETCH;
                        end else begin
                            csum_ok <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prom_boot_reader.sv
// tb_prom_boot_reader: directed bench, three loaders (ACCESS_CYCLES 2/1/4) sharing one PROM image.
`default_nettype none

module tb_prom_boot_reader;

    localparam int AC_T [3] = '{2, 1, 4};
`ifdef PROM_CHECKSUM_EN
    localparam int EXTRA    = 1;
    localparam bit EXP_CSUM = 1'b0;
`else
    localparam int EXTRA    = 0;
    localparam bit EXP_CSUM = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  start;
    logic        wr_ready;
    logic        clear_logs;
    logic [7:0]  mem [512];

    logic [8:0]  prom_a  [3];
    logic [13:0] wr_addr [3];
    logic [47:0] wr_data [3];
    logic [2:0]  prom_ce_n, wr_valid, busy, done, csum_ok;

    int          nwr [3], ndone [3], ce_low [3], stall_chg [3], valid_cyc [3];
    logic [13:0] la [3][4];
    logic [47:0] ld [3][4];
    logic        saw511 [3];
    logic        prev_stall [3];
    logic [47:0] pdat [3];
    logic [13:0] padr [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int AC = AC_T[gi];
        logic [8:0] prev_a;
        logic       prev_low;
        int         run;
        int         age;
        logic [7:0] pd;

        // PROM model: data only becomes valid after AC clocks of stable address with CE low
        always_comb begin
            age = (prev_low && prom_a[gi] == prev_a) ? run : 0;
            if (prom_ce_n[gi])
                pd = 8'hzz;
            else if (age >= AC)
                pd = mem[prom_a[gi]];
            else
                pd = 8'hEE;
        end

        initial begin
            prev_a = '0;
            prev_low = 1'b0;
            run = 0;
        end

        always @(posedge clk) begin
            prev_a   <= prom_a[gi];
            prev_low <= !prom_ce_n[gi];
            run      <= !prom_ce_n[gi] ? ((prev_low && prom_a[gi] == prev_a) ? run + 1 : 1) : 0;
        end

        prom_boot_reader #(
            .ACCESS_CYCLES(AC),
            .NUM_WORDS    (2)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start[gi]),
            .prom_a   (prom_a[gi]),
            .prom_ce_n(prom_ce_n[gi]),
            .prom_d   (pd),
            .wr_valid (wr_valid[gi]),
            .wr_ready (wr_ready),
            .wr_addr  (wr_addr[gi]),
            .wr_data  (wr_data[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .csum_ok  (csum_ok[gi])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clear_logs) begin
                nwr[k] <= 0; ndone[k] <= 0; ce_low[k] <= 0; stall_chg[k] <= 0;
                valid_cyc[k] <= 0; saw511[k] <= 1'b0; prev_stall[k] <= 1'b0;
            end else begin
                if (!prom_ce_n[k]) ce_low[k] <= ce_low[k] + 1;
                if (!prom_ce_n[k] && prom_a[k] == 9'd511) saw511[k] <= 1'b1;
                if (wr_valid[k]) valid_cyc[k] <= valid_cyc[k] + 1;
                if (wr_valid[k] && wr_ready) begin
                    if (nwr[k] < 4) begin
                        la[k][nwr[k][1:0]] <= wr_addr[k];
                        ld[k][nwr[k][1:0]] <= wr_data[k];
                    end
                    nwr[k] <= nwr[k] + 1;
                end
                if (done[k]) ndone[k] <= ndone[k] + 1;
                if (prev_stall[k] && (wr_data[k] !== pdat[k] || wr_addr[k] !== padr[k]))
                    stall_chg[k] <= stall_chg[k] + 1;
                prev_stall[k] <= wr_valid[k] && !wr_ready;
                pdat[k] <= wr_data[k];
                padr[k] <= wr_addr[k];
            end
        end
    end

    task automatic clr();
        clear_logs = 1'b1;
        @(negedge clk);
        clear_logs = 1'b0;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ndone[i] > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (prom_ce_n[0] !== 1'b1) begin failures++; $display("FAIL rst_ce_n got=%b exp=1", prom_ce_n[0]); end
        if (prom_a[0] !== 9'd0) begin failures++; $display("FAIL rst_prom_a got=%0d exp=0", prom_a[0]); end
        if (wr_valid[0] !== 1'b0) begin failures++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid[0]); end
        if (wr_addr[0] !== 14'd0) begin failures++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr[0]); end
        if (wr_data[0] !== 48'd0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", wr_data[0]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
        if (done[0] !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done[0]); end
        if (csum_ok[0] !== 1'b0) begin failures++; $display("FAIL rst_csum_ok got=%b exp=0", csum_ok[0]); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        wr_ready = 1'b1;
        clr();
        pulse_start(0);
        checks += 2;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy[0]); end
        if (csum_ok[0] !== 1'b0) begin failures++; $display("FAIL basic_csum_during got=%b exp=0", csum_ok[0]); end
        wait_done(0, 500, to);
        checks += 10;
        if (to) begin failures++; $display("FAIL basic_timeout got=none exp=done"); end
        if (nwr[0] !== 2) begin failures++; $display("FAIL basic_nwr got=%0d exp=2", nwr[0]); end
        if (la[0][0] !== 14'd0) begin failures++; $display("FAIL basic_addr0 got=%0d exp=0", la[0][0]); end
        if (ld[0][0] !== 48'h050403020100) begin failures++; $display("FAIL basic_data0 got=%h exp=050403020100", ld[0][0]); end
        if (la[0][1] !== 14'd1) begin failures++; $display("FAIL basic_addr1 got=%0d exp=1", la[0][1]); end
        if (ld[0][1] !== 48'h0B0A09080706) begin failures++; $display("FAIL basic_data1 got=%h exp=0B0A09080706", ld[0][1]); end
        if (ndone[0] !== 1) begin failures++; $display("FAIL basic_ndone got=%0d exp=1", ndone[0]); end
        if (ce_low[0] !== (12 + EXTRA) * 3) begin failures++; $display("FAIL basic_ce_low got=%0d exp=%0d", ce_low[0], (12 + EXTRA) * 3); end
        if (saw511[0] !== 1'(EXTRA)) begin failures++; $display("FAIL basic_addr511 got=%b exp=%0d", saw511[0], EXTRA); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy[0]); end
        repeat (5) @(negedge clk);
        checks++;
        if (csum_ok[0] !== EXP_CSUM) begin failures++; $display("FAIL basic_csum_ok got=%b exp=%b", csum_ok[0], EXP_CSUM); end
    endtask

    task automatic test_stall();
        bit to;
        bit seen;
        wr_ready = 1'b0;
        clr();
        pulse_start(0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (wr_valid[0]) seen = 1'b1;
            else @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks += 2;
        if (!seen) begin failures++; $display("FAIL stall_no_valid got=0 exp=1"); end
        if (wr_valid[0] !== 1'b1) begin failures++; $display("FAIL stall_valid_held got=%b exp=1", wr_valid[0]); end
        wr_ready = 1'b1;
        wait_done(0, 500, to);
        checks += 6;
        if (to) begin failures++; $display("FAIL stall_timeout got=none exp=done"); end
        if (nwr[0] !== 2) begin failures++; $display("FAIL stall_nwr got=%0d exp=2", nwr[0]); end
        if (valid_cyc[0] !== 12) begin failures++; $display("FAIL stall_valid_cycles got=%0d exp=12", valid_cyc[0]); end
        if (stall_chg[0] !== 0) begin failures++; $display("FAIL stall_data_changed got=%0d exp=0", stall_chg[0]); end
        if (ld[0][0] !== 48'h050403020100) begin failures++; $display("FAIL stall_data0 got=%h exp=050403020100", ld[0][0]); end
        if (ld[0][1] !== 48'h0B0A09080706) begin failures++; $display("FAIL stall_data1 got=%h exp=0B0A09080706", ld[0][1]); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        wr_ready = 1'b1;
        clr();
        pulse_start(0);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (prom_a[0] == 9'd9 && !prom_ce_n[0]) hit = 1'b1;
            else @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks += 9;
        if (!hit) begin failures++; $display("FAIL mid_no_byte9 got=0 exp=1"); end
        if (prom_ce_n[0] !== 1'b1) begin failures++; $display("FAIL mid_ce_n got=%b exp=1", prom_ce_n[0]); end
        if (prom_a[0] !== 9'd0) begin failures++; $display("FAIL mid_prom_a got=%0d exp=0", prom_a[0]); end
        if (wr_valid[0] !== 1'b0) begin failures++; $display("FAIL mid_wr_valid got=%b exp=0", wr_valid[0]); end
        if (wr_addr[0] !== 14'd0) begin failures++; $display("FAIL mid_wr_addr got=%0d exp=0", wr_addr[0]); end
        if (wr_data[0] !== 48'd0) begin failures++; $display("FAIL mid_wr_data got=%h exp=0", wr_data[0]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy[0]); end
        if (done[0] !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done[0]); end
        if (csum_ok[0] !== 1'b0) begin failures++; $display("FAIL mid_csum_ok got=%b exp=0", csum_ok[0]); end
        reset_n = 1'b1;
        clr();
        repeat (20) @(negedge clk);
        checks += 2;
        if (nwr[0] !== 0) begin failures++; $display("FAIL mid_spurious_write got=%0d exp=0", nwr[0]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL mid_busy_after got=%b exp=0", busy[0]); end
        pulse_start(0);
        wait_done(0, 500, to);
        checks += 3;
        if (to) begin failures++; $display("FAIL mid_reload_timeout got=none exp=done"); end
        if (la[0][0] !== 14'd0) begin failures++; $display("FAIL mid_reload_addr0 got=%0d exp=0", la[0][0]); end
        if (ld[0][0] !== 48'h050403020100) begin failures++; $display("FAIL mid_reload_data0 got=%h exp=050403020100", ld[0][0]); end
    endtask

    task automatic test_start_spam();
        bit to;
        wr_ready = 1'b1;
        clr();
        start[0] = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done[0]) begin
                to = 1'b0;
                break;
            end
        end
        // start is still high on the clock that ends the done pulse
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        checks += 6;
        if (to) begin failures++; $display("FAIL spam_timeout got=none exp=done"); end
        if (nwr[0] !== 2) begin failures++; $display("FAIL spam_nwr got=%0d exp=2", nwr[0]); end
        if (ndone[0] !== 1) begin failures++; $display("FAIL spam_ndone got=%0d exp=1", ndone[0]); end
        if (ld[0][0] !== 48'h050403020100) begin failures++; $display("FAIL spam_data0 got=%h exp=050403020100", ld[0][0]); end
        if (ld[0][1] !== 48'h0B0A09080706) begin failures++; $display("FAIL spam_data1 got=%h exp=0B0A09080706", ld[0][1]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL spam_busy got=%b exp=0", busy[0]); end
    endtask

    task automatic test_access_cycles();
        bit to1;
        bit to2;
        wr_ready = 1'b1;
        clr();
        start[1] = 1'b1;
        start[2] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        start[2] = 1'b0;
        wait_done(1, 500, to1);
        wait_done(2, 500, to2);
        checks += 8;
        if (to1 || to2) begin failures++; $display("FAIL ac_timeout got=%b%b exp=00", to1, to2); end
        if (ce_low[1] !== (12 + EXTRA) * 2) begin failures++; $display("FAIL ac1_ce_low got=%0d exp=%0d", ce_low[1], (12 + EXTRA) * 2); end
        if (ce_low[2] !== (12 + EXTRA) * 5) begin failures++; $display("FAIL ac4_ce_low got=%0d exp=%0d", ce_low[2], (12 + EXTRA) * 5); end
        if (ld[1][0] !== 48'h050403020100) begin failures++; $display("FAIL ac1_data0 got=%h exp=050403020100", ld[1][0]); end
        if (ld[1][1] !== 48'h0B0A09080706) begin failures++; $display("FAIL ac1_data1 got=%h exp=0B0A09080706", ld[1][1]); end
        if (ld[2][0] !== 48'h050403020100) begin failures++; $display("FAIL ac4_data0 got=%h exp=050403020100", ld[2][0]); end
        if (ld[2][1] !== 48'h0B0A09080706) begin failures++; $display("FAIL ac4_data1 got=%h exp=0B0A09080706", ld[2][1]); end
        if (ndone[1] !== 1 || ndone[2] !== 1) begin failures++; $display("FAIL ac_ndone got=%0d,%0d exp=1,1", ndone[1], ndone[2]); end
    endtask

`ifdef PROM_CHECKSUM_EN
    task automatic test_checksum();
        bit to;
        for (int n = 0; n < 12; n++) mem[n] = 8'h01;
        for (int pass = 0; pass < 2; pass++) begin
            // twelve bytes of 1 sum to 12; F4 cancels it, F5 leaves 1
            mem[511] = (pass == 0) ? 8'hF4 : 8'hF5;
            wr_ready = 1'b1;
            clr();
            pulse_start(0);
            wait_done(0, 500, to);
            checks += 3;
            if (to) begin failures++; $display("FAIL csum_timeout pass=%0d got=none exp=done", pass); end
            if (saw511[0] !== 1'b1) begin failures++; $display("FAIL csum_addr511 pass=%0d got=%b exp=1", pass, saw511[0]); end
            if (csum_ok[0] !== (pass == 0)) begin failures++; $display("FAIL csum_ok pass=%0d got=%b exp=%0d", pass, csum_ok[0], pass == 0); end
        end
        for (int n = 0; n < 512; n++) mem[n] = 8'(n);
    endtask
`endif

    initial begin
        for (int n = 0; n < 512; n++) mem[n] = 8'(n);
        reset_n    = 1'b0;
        start      = 3'b000;
        wr_ready   = 1'b1;
        clear_logs = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_start_spam();
        test_access_cycles();
`ifdef PROM_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
